// File: rtl/ddr4_rd_port_arbiter.sv
// Round-robin read front end: merges NUM_CH client read requests onto one AXI4 AR channel,
// splits bursts at 4 KB pages and steers R beats back to the clients by RID.
module ddr4_rd_port_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     calib_i,
  input  logic [NUM_CH-1:0]        req_valid_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_CH*8-1:0]      req_len_i,
  output logic [NUM_CH-1:0]        rd_valid_o,
  input  logic [NUM_CH-1:0]        rd_ready_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_last_o,
  output logic                     err_o,
  output logic [ADDR_W-1:0]        m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [ID_W-1:0]          m_axi_arid,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [DATA_W-1:0]        m_axi_rdata,
  input  logic [ID_W-1:0]          m_axi_rid,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam int BPB   = DATA_W / 8;
  localparam int OFF_W = $clog2(BPB);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE, AR1, AR2} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   cap_ch;
  logic [ADDR_W-1:0] cap_addr;
  logic [7:0]        cap_len;
  logic [CNT_W-1:0]  outst [NUM_CH];

  logic [NUM_CH-1:0] eligible;
  logic              grant_any;
  logic [CH_W-1:0]   grant_ch;
  logic [ADDR_W-1:0] grant_addr;
  logic [7:0]        grant_len;

  logic [12:0]       bnd;
  logic              fits;
  logic [7:0]        first_len;
  logic [7:0]        rem_len;
  logic [ADDR_W-1:0] rem_addr;

  logic              ar_hs;
  logic              r_hs;
  logic              rid_ok;

  // The +2 headroom keeps a channel from being granted a request that might split into two bursts.
  always_comb begin
    eligible = '0;
    for (int c = 0; c < NUM_CH; c++)
      eligible[c] = req_valid_i[c] && calib_i && (int'(outst[c]) + 2 <= MAX_OUTST);
  end

  always_comb begin
    grant_any  = 1'b0;
    grant_ch   = '0;
    grant_addr = '0;
    grant_len  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[CH_W'((int'(ptr) + i) % NUM_CH)]) begin
        grant_any = 1'b1;
        grant_ch  = CH_W'((int'(ptr) + i) % NUM_CH);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(grant_ch) == c) begin
        grant_addr = req_addr_i[c*ADDR_W +: ADDR_W] & ~(ADDR_W'(BPB - 1));
        grant_len  = req_len_i[c*8 +: 8];
      end
    end
  end

  // Beats left before the next 4 KB page; a longer burst is cut there and the rest issued from AR2.
  always_comb begin
    bnd       = 13'((4096 - int'(cap_addr[11:0])) >> OFF_W);
    fits      = (int'(cap_len) + 1 <= int'(bnd));
    first_len = fits ? cap_len : 8'(int'(bnd) - 1);
    rem_len   = 8'(int'(cap_len) - int'(bnd));
    rem_addr  = (cap_addr | ADDR_W'(12'hFFF)) + ADDR_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = AR1;
      AR1:     if (m_axi_arready) state_nxt = fits ? IDLE : AR2;
      AR2:     if (m_axi_arready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = '0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = cap_addr;
    m_axi_arlen   = cap_len;
    case (state)
      IDLE:    if (grant_any) req_ready_o[grant_ch] = 1'b1;
      AR1: begin
        m_axi_arvalid = 1'b1;
        m_axi_arlen   = first_len;
      end
      AR2:     m_axi_arvalid = 1'b1;
      default: ;
    endcase
  end

  assign m_axi_arid    = ID_W'(cap_ch);
  assign m_axi_arsize  = 3'(OFF_W);
  assign m_axi_arburst = 2'b01;
  assign ar_hs         = m_axi_arvalid && m_axi_arready;

  // After a split handshake the capture registers are reloaded with the second half for AR2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr      <= '0;
      cap_ch   <= '0;
      cap_addr <= '0;
      cap_len  <= '0;
    end else if (state == IDLE && grant_any) begin
      ptr      <= CH_W'((int'(grant_ch) + 1) % NUM_CH);
      cap_ch   <= grant_ch;
      cap_addr <= grant_addr;
      cap_len  <= grant_len;
    end else if (state == AR1 && ar_hs && !fits) begin
      cap_addr <= rem_addr;
      cap_len  <= rem_len;
    end
  end

  // Beats carrying an unknown RID are accepted and discarded so the R channel never stalls.
  always_comb begin
    rid_ok       = int'(m_axi_rid) < NUM_CH;
    rd_valid_o   = '0;
    m_axi_rready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(m_axi_rid) == c) begin
        rd_valid_o[c] = m_axi_rvalid;
        m_axi_rready  = rd_ready_i[c];
      end
    end
  end

  assign rd_data_o = m_axi_rdata;
  assign rd_last_o = m_axi_rlast;
  assign r_hs      = m_axi_rvalid && m_axi_rready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) outst[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((ar_hs && int'(cap_ch) == c) && !(r_hs && m_axi_rlast && int'(m_axi_rid) == c))
          outst[c] <= outst[c] + CNT_W'(1);
        else if (!(ar_hs && int'(cap_ch) == c) && (r_hs && m_axi_rlast && int'(m_axi_rid) == c))
          outst[c] <= outst[c] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      err_o <= 1'b0;
    else if (r_hs && (m_axi_rresp != 2'b00 || !rid_ok))
      err_o <= 1'b1;
  end

endmodule

// File: tb/tb_ddr4_rd_port_arbiter.sv
// Bench for ddr4_rd_port_arbiter: directed scenarios plus a random run, all checked against
// a transaction-level model (request queue, page-split arithmetic, per-channel burst counts).
module tb_ddr4_rd_port_arbiter;

  localparam int NUM_CH    = 4;
  localparam int MAX_OUTST = 4;
  localparam int BPB       = 8;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               calib = 1'b0;
  logic [3:0]         req_valid = '0;
  logic [31:0]        req_addr [NUM_CH];
  logic [7:0]         req_len  [NUM_CH];
  logic [3:0]         rd_ready = '0;
  logic               arready = 1'b0;
  logic [63:0]        rdata = '0;
  logic [3:0]         rid = '0;
  logic [1:0]         rresp = '0;
  logic               rlast = 1'b0;
  logic               rvalid = 1'b0;

  logic [NUM_CH*32-1:0] req_addr_bus;
  logic [NUM_CH*8-1:0]  req_len_bus;
  logic [3:0]   req_ready_o, rd_valid_o;
  logic [63:0]  rd_data_o;
  logic         rd_last_o, err_o;
  logic [31:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [3:0]   m_axi_arid;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arvalid, m_axi_rready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign req_addr_bus[c*32 +: 32] = req_addr[c];
    assign req_len_bus[c*8 +: 8]    = req_len[c];
  end

  ddr4_rd_port_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .calib_i(calib),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_bus), .req_len_i(req_len_bus),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready), .rd_data_o(rd_data_o),
    .rd_last_o(rd_last_o), .err_o(err_o),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arid(m_axi_arid),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rid(rid), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } ar_t;

  typedef struct {
    int id;
    int left;
  } burst_t;

  ar_t    arq[$];
  ar_t    obs_ar[$];
  burst_t rq[$];
  int     m_outst [NUM_CH];
  int     m_ptr;
  logic   err_m;
  int     last_grant;
  logic   last_r_hs;
  logic   auto_r;

  logic [3:0] obs_ready;
  logic       obs_arvalid;
  int         ready_pulses;
  int         arvalid_cycles;
  int         rready_cycles;

  int num_compared   = 0;
  int num_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_compared++;
    if (obs !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A request becomes one burst, or two when its byte range runs past the end of its 4 KB page.
  function automatic void push_request(input int ch, input logic [31:0] addr, input int len);
    longint a, page_end, bytes, first;
    ar_t e;
    a        = longint'(addr & ~32'(BPB - 1));
    page_end = (a / 4096 + 1) * 4096;
    bytes    = longint'(len + 1) * BPB;
    e.id     = 4'(ch);
    e.addr   = a[31:0];
    if (a + bytes <= page_end) begin
      e.len = 8'(len);
      arq.push_back(e);
    end else begin
      first = (page_end - a) / BPB;
      e.len = 8'(first - 1);
      arq.push_back(e);
      e.addr = page_end[31:0];
      e.len  = 8'(longint'(len) - first);
      arq.push_back(e);
    end
  endfunction

  task automatic applyStimulus();
    int         g;
    logic [3:0] exp_ready, exp_rdv;
    logic       exp_arvalid, rid_ok, exp_rready, r_hs;
    #1;
    g = -1;
    if (arq.size() == 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        int c;
        c = (m_ptr + i) % NUM_CH;
        if (g < 0 && req_valid[c] && calib && m_outst[c] + 2 <= MAX_OUTST) g = c;
      end
    end
    exp_ready   = (g >= 0) ? 4'(1 << g) : 4'b0;
    exp_arvalid = arq.size() != 0;
    rid_ok      = rid < 4'(NUM_CH);
    exp_rready  = rid_ok ? rd_ready[rid[1:0]] : 1'b1;
    exp_rdv     = (rvalid && rid_ok) ? 4'(1 << rid[1:0]) : 4'b0;
    r_hs        = rvalid && exp_rready;

    checkOutput("req_ready", 64'(req_ready_o), 64'(exp_ready));
    checkOutput("arvalid", 64'(m_axi_arvalid), 64'(exp_arvalid));
    if (exp_arvalid)
      checkOutput("ar_fields", 64'({m_axi_araddr, m_axi_arlen, m_axi_arid}), 64'(arq[0]));
    checkOutput("rd_valid", 64'(rd_valid_o), 64'(exp_rdv));
    checkOutput("rready", 64'(m_axi_rready), 64'(exp_rready));
    checkOutput("rd_data", rd_data_o, rdata);
    checkOutput("rd_last", 64'(rd_last_o), 64'(rlast));

    obs_ready   = req_ready_o;
    obs_arvalid = m_axi_arvalid;
    if (req_ready_o != 0) ready_pulses++;
    if (m_axi_arvalid) arvalid_cycles++;
    if (m_axi_rready) rready_cycles++;
    if (m_axi_arvalid && arready) begin
      ar_t o;
      o.addr = m_axi_araddr;
      o.len  = m_axi_arlen;
      o.id   = m_axi_arid;
      obs_ar.push_back(o);
    end

    @(posedge clk_i);
    if (g >= 0) begin
      push_request(g, req_addr[g], int'(req_len[g]));
      m_ptr = (g + 1) % NUM_CH;
    end else if (exp_arvalid && arready) begin
      burst_t b;
      m_outst[arq[0].id] = m_outst[arq[0].id] + 1;
      b.id   = int'(arq[0].id);
      b.left = int'(arq[0].len) + 1;
      rq.push_back(b);
      void'(arq.pop_front());
    end
    if (r_hs) begin
      if (rid_ok && rlast) m_outst[rid[1:0]] = m_outst[rid[1:0]] - 1;
      if (rresp != 2'b00 || !rid_ok) err_m = 1'b1;
      if (auto_r && rq.size() > 0) begin
        rq[0].left = rq[0].left - 1;
        if (rq[0].left == 0) void'(rq.pop_front());
      end
    end
    last_r_hs  = r_hs;
    last_grant = g;
    #1;
    checkOutput("err", 64'(err_o), 64'(err_m));
    @(negedge clk_i);
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    req_valid = '0; rvalid = 1'b0; rlast = 1'b0; rresp = '0; rid = '0;
    arready = 1'b0; calib = 1'b0; rd_ready = '0;
    arq.delete(); rq.delete(); obs_ar.delete();
    for (int c = 0; c < NUM_CH; c++) m_outst[c] = 0;
    m_ptr = 0; err_m = 1'b0; last_grant = -1; last_r_hs = 1'b0; auto_r = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
    checkOutput("rst_req_ready", 64'(req_ready_o), 64'(0));
    checkOutput("rst_err", 64'(err_o), 64'(0));
    rst_i = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      req_addr[c] = '0;
      req_len[c]  = '0;
    end

    doReset();
    checkOutput("arsize", 64'(m_axi_arsize), 64'(3));
    checkOutput("arburst", 64'(m_axi_arburst), 64'(1));

    // Calibration gate.
    arready = 1'b1; req_addr[0] = 32'h100; req_len[0] = 8'd3; req_valid = 4'b0001;
    arvalid_cycles = 0;
    for (int i = 0; i < 20; i++) applyStimulus();
    checkOutput("calib_hold_arvalid", 64'(arvalid_cycles), 64'(0));
    calib = 1'b1;
    applyStimulus();
    checkOutput("calib_grant", 64'(obs_ready), 64'(4'b0001));
    req_valid = '0;
    applyStimulus();
    checkOutput("calib_arvalid", 64'(obs_arvalid), 64'(1));

    // Round robin between channels 0 and 2.
    doReset();
    calib = 1'b1; arready = 1'b1;
    req_addr[0] = 32'h2000; req_len[0] = 8'd0;
    req_addr[2] = 32'h3000; req_len[2] = 8'd0;
    req_valid = 4'b0101;
    for (int i = 0; i < 16; i++) applyStimulus();
    if (obs_ar.size() >= 3) begin
      checkOutput("rr_id0", 64'(obs_ar[0].id), 64'(0));
      checkOutput("rr_id1", 64'(obs_ar[1].id), 64'(2));
      checkOutput("rr_id2", 64'(obs_ar[2].id), 64'(0));
    end else checkOutput("rr_count", 64'(obs_ar.size()), 64'(3));
    begin
      int n0, n2;
      n0 = 0; n2 = 0;
      foreach (obs_ar[k]) begin
        if (obs_ar[k].id == 4'd0) n0++;
        if (obs_ar[k].id == 4'd2) n2++;
      end
      checkOutput("rr_ch0_bursts", 64'(n0), 64'(3));
      checkOutput("rr_ch2_bursts", 64'(n2), 64'(3));
    end

    // 4 KB split.
    doReset();
    calib = 1'b1; arready = 1'b1;
    req_addr[1] = 32'h0000_0FC0; req_len[1] = 8'd15; req_valid = 4'b0010;
    applyStimulus();
    req_valid = '0;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("split_count", 64'(obs_ar.size()), 64'(2));
    if (obs_ar.size() >= 2) begin
      checkOutput("split_first", 64'(obs_ar[0]), 64'({32'h0000_0FC0, 8'd7, 4'd1}));
      checkOutput("split_second", 64'(obs_ar[1]), 64'({32'h0000_1000, 8'd7, 4'd1}));
    end

    // Outstanding limit on channel 0, released by one rlast beat.
    doReset();
    calib = 1'b1; arready = 1'b1;
    req_addr[0] = 32'h40; req_len[0] = 8'd0; req_valid = 4'b0001;
    ready_pulses = 0;
    for (int i = 0; i < 12; i++) applyStimulus();
    checkOutput("outst_block_grants", 64'(ready_pulses), 64'(3));
    rd_ready = 4'b1111; rid = 4'd0; rlast = 1'b1; rvalid = 1'b1; rdata = 64'h1111_2222_3333_4444;
    applyStimulus();
    rvalid = 1'b0; rlast = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("outst_release_grants", 64'(ready_pulses), 64'(4));

    // R routing to channel 2 with toggling ready.
    doReset();
    rvalid = 1'b1; rid = 4'd2; rlast = 1'b0; rdata = 64'hDEAD_BEEF_0123_4567;
    rready_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      rd_ready = (i % 2 == 1) ? 4'b0100 : 4'b1011;
      applyStimulus();
    end
    checkOutput("route_rready_cycles", 64'(rready_cycles), 64'(3));

    // Sticky error from SLVERR, then from an unknown RID.
    doReset();
    rd_ready = 4'b1111; rid = 4'd1; rresp = 2'b10; rvalid = 1'b1;
    applyStimulus();
    rresp = 2'b00;
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("err_sticky", 64'(err_o), 64'(1));
    doReset();
    rd_ready = 4'b0000; rid = 4'd7; rvalid = 1'b1;
    applyStimulus();
    rvalid = 1'b0;
    checkOutput("err_bad_rid", 64'(err_o), 64'(1));

    // Asynchronous reset while an AR is pending.
    doReset();
    calib = 1'b1; arready = 1'b0;
    req_addr[3] = 32'h8000; req_len[3] = 8'd4; req_valid = 4'b1000;
    applyStimulus();
    req_valid = '0;
    #2;
    checkOutput("ar1_arvalid", 64'(m_axi_arvalid), 64'(1));
    rst_i = 1'b1;
    #1;
    checkOutput("async_rst_arvalid", 64'(m_axi_arvalid), 64'(0));
    @(negedge clk_i);
    doReset();

    // Random traffic against the model.
    auto_r = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      calib   = ($urandom_range(0, 15) != 0);
      arready = ($urandom_range(0, 2) != 0);
      rd_ready = 4'($urandom);
      for (int c = 0; c < NUM_CH; c++) begin
        if (last_grant == c) req_valid[c] = 1'b0;
        if (!req_valid[c] && $urandom_range(0, 3) == 0) begin
          req_addr[c] = $urandom;
          if ($urandom_range(0, 1) == 1) req_addr[c][11:0] = 12'(12'hF00 + $urandom_range(0, 255));
          req_len[c] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
          req_valid[c] = 1'b1;
        end
      end
      if (!rvalid || last_r_hs) begin
        if (rq.size() > 0 && $urandom_range(0, 3) != 0) begin
          rvalid = 1'b1;
          rid    = 4'(rq[0].id);
          rdata  = {$urandom, $urandom};
          rresp  = 2'b00;
          rlast  = (rq[0].left == 1);
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end
      end
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
